reg_bank_arbiter: RTL and testbench
===================================

# reg_bank_arbiter

Round-robin arbiter and sequencer for a shared bank of DEPTH D-flip-flop data registers. Up to NREQ requesters issue read or write accesses through a req/gnt handshake. The block grants one requester at a time, performs the bank access, and returns read data tagged with the requester ID. It sits between the requester logic and the register bank, which it owns internally.

## Interface
Parameters:
- NREQ, 4, number of requesters; must be a power of two, 2..8
- IW, 2, requester ID width, log2(NREQ)
- DEPTH, 4, number of bank registers, power of two
- AW, 2, bank address width, log2(DEPTH)
- DW, 8, data width of each bank register

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  NREQ  request per requester; bit i belongs to requester i
- wr  in  NREQ  access type per requester: 1 = write, 0 = read
- addr  in  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW]
- wdata  in  NREQ*DW  packed write data; requester i uses bits [i*DW +: DW]
- gnt  out  NREQ  one-hot grant; high for exactly one cycle per access
- rvalid  out  1  one-cycle pulse; rdata and rid are valid
- rdata  out  DW  bank contents at the granted address before the access (read-before-write)
- rid  out  IW  ID of the requester that owns rdata
- busy  out  1  high while the FSM is in GRANT

## Operation
- FSM states:
  - IDLE: if |req is 1, register the round-robin winner into gnt and go to GRANT. Otherwise stay in IDLE.
  - GRANT: gnt is one-hot and busy=1. At the closing edge, perform the access, clear gnt, and always return to IDLE.
- Round robin:
  - Search starts at (ptr+1) mod NREQ and wraps upward. The first asserted req wins.
  - ptr <= winner when the grant is issued.
  - Reset value of ptr is NREQ-1, so requester 0 has top priority after reset.
- Access performed at the edge ending the GRANT cycle, for granted requester k:
  - rdata <= bank[addr_k]
  - rid <= k
  - rvalid <= 1
  - if wr_k, bank[addr_k] <= wdata_k
- Reads also pulse rvalid. Writes pulse rvalid with the old contents, which gives swap semantics.
- Requester contract:
  - Hold req, wr, addr and wdata stable from assertion until the cycle gnt is high.
  - Drop req in the cycle after gnt, or keep it high to request another access.
  - Deasserting req while waiting (before gnt) is legal and withdraws the request.
- Inputs are sampled for arbitration only in IDLE. Inputs for the access are taken from the granted requester during GRANT.
- Bank storage is internal and reset to all zeros.

## Timing
- Reset values (asynchronous, while rst=0): gnt=0, rvalid=0, rdata=0, rid=0, busy=0, state=IDLE, ptr=NREQ-1, bank all 0.
- Reset asserted mid-GRANT: the access is abandoned, the bank is cleared, and no rvalid pulse follows. Operation resumes on the first edge after rst rises.
- Latency:
  - req high in cycle N while in IDLE gives gnt high in cycle N+1.
  - rvalid high in cycle N+2.
  - A written value is visible to a read granted in cycle N+3 or later.
- Throughput is one access per 2 cycles. The mandatory IDLE cycle guarantees a requester that drops req right after gnt is never re-granted.
- rvalid is high only in the IDLE cycle following GRANT. rdata and rid hold their value until the next access.
- All requesters hold req continuously: grants rotate 0,1,2,3,0,… with gnt in every other cycle.
- Only one requester active: it is granted every other cycle regardless of ptr.
- Address and data widths are exact. There is no wrap or overflow condition, since addr always indexes within DEPTH.

## Test plan
- Reset then single write: req[0]=1, wr[0]=1, addr0=2, wdata0=0xA5 → gnt=0001 one cycle later; rvalid next with rdata=0x00, rid=0. A following read of addr 2 by requester 1 → rdata=0xA5, rid=1.
- Full contention: req=1111, all reads, held for 16 cycles → gnt sequence 0001,0010,0100,1000,0001 on alternate cycles. rid follows 0,1,2,3,0.
- Fairness after a skip: req=0101 held → grants alternate between requester 0 and requester 2. Requester 2 is never starved and requesters 1 and 3 are never granted.
- Same-address swap: requester 1 writes 0x3C to addr 1, then requester 3 writes 0xC3 to addr 1 → second rvalid returns rdata=0x3C. A subsequent read returns 0xC3.
- Withdrawal: req[2] pulses for one cycle while requester 0 is being granted → requester 2 is never granted and no rvalid appears with rid=2.
- Async reset mid-GRANT, during a write of 0xFF to addr 3 → gnt drops immediately and no rvalid follows. A read of addr 3 after reset returns 0x00, and the first grant goes to the lowest asserted requester.

Source files
------------

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: round-robin arbiter that sequences one read-before-write access
// at a time into an internal register bank and returns tagged read data.
module reg_bank_arbiter #(
   parameter int NREQ  = 4,
   parameter int IW    = 2,
   parameter int DEPTH = 4,
   parameter int AW    = 2,
   parameter int DW    = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    wr,
   input  logic [NREQ*AW-1:0] addr,
   input  logic [NREQ*DW-1:0] wdata,
   output logic [NREQ-1:0]    gnt,
   output logic               rvalid,
   output logic [DW-1:0]      rdata,
   output logic [IW-1:0]      rid,
   output logic               busy
);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t          state_q;
   logic [NREQ-1:0] gnt_q;
   logic [IW-1:0]   ptr_q, gid_q, rid_q, gid_d;
   logic            rvalid_q, busy_q;
   logic [DW-1:0]   rdata_q;
   logic [DW-1:0]   bank_q [DEPTH];
   logic [AW-1:0]   acc_addr;
   // Scan offsets from farthest to nearest so the nearest requester after ptr wins.
   always_comb begin
      gid_d = ptr_q;
      for (int o = NREQ; o >= 1; o--)
         if (req[ptr_q + IW'(o)]) gid_d = ptr_q + IW'(o);
   end
   assign acc_addr = addr[gid_q*AW +: AW];
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         ptr_q    <= IW'(NREQ-1);
         gid_q    <= '0;
         rvalid_q <= 1'b0;
         busy_q   <= 1'b0;
         rdata_q  <= '0;
         rid_q    <= '0;
         for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
      end else if (state_q == IDLE) begin
         rvalid_q <= 1'b0;
         if (|req) begin
            gnt_q   <= NREQ'(1) << gid_d;
            gid_q   <= gid_d;
            ptr_q   <= gid_d;
            busy_q  <= 1'b1;
            state_q <= GRANT;
         end
      end else begin
         rdata_q  <= bank_q[acc_addr];
         rid_q    <= gid_q;
         rvalid_q <= 1'b1;
         if (wr[gid_q]) bank_q[acc_addr] <= wdata[gid_q*DW +: DW];
         gnt_q    <= '0;
         busy_q   <= 1'b0;
         state_q  <= IDLE;
      end
   end
   assign gnt    = gnt_q;
   assign rvalid = rvalid_q;
   assign rdata  = rdata_q;
   assign rid    = rid_q;
   assign busy   = busy_q;
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter: directed and random stimulus against a behavioural arbiter/bank model.
module tb_reg_bank_arbiter;
   localparam int NREQ = 4, IW = 2, DEPTH = 4, AW = 2, DW = 8;
   logic               clk = 1'b0, rst = 1'b0;
   logic [NREQ-1:0]    req = '0, wr = '0;
   logic [NREQ*AW-1:0] addr = '0;
   logic [NREQ*DW-1:0] wdata = '0;
   logic [NREQ-1:0]    gnt;
   logic               rvalid, busy;
   logic [DW-1:0]      rdata;
   logic [IW-1:0]      rid;
   int n_vec = 0, n_err = 0;
   int m_busy, m_gnt, m_ptr, m_rvalid, m_rdata, m_rid;
   int m_bank [DEPTH];

   reg_bank_arbiter #(.NREQ(NREQ), .IW(IW), .DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
      .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .rid(rid), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      m_busy = 0; m_gnt = -1; m_ptr = NREQ-1; m_rvalid = 0; m_rdata = 0; m_rid = 0;
      for (int i = 0; i < DEPTH; i++) m_bank[i] = 0;
   endfunction

   // One clock edge of the access protocol: arbitrate when idle, otherwise serve the grantee.
   function automatic void model_step();
      int k, a;
      if (!rst) begin
         model_reset();
         return;
      end
      if (m_busy == 0) begin
         m_rvalid = 0;
         if (req != 0) begin
            for (int o = 1; o <= NREQ; o++)
               if (req[(m_ptr+o)%NREQ]) begin
                  m_gnt = (m_ptr+o)%NREQ;
                  break;
               end
            m_ptr = m_gnt;
            m_busy = 1;
         end
      end else begin
         k = m_gnt;
         a = int'(addr[k*AW +: AW]);
         m_rdata = m_bank[a];
         m_rid = k;
         m_rvalid = 1;
         if (wr[k]) m_bank[a] = int'(wdata[k*DW +: DW]);
         m_busy = 0;
         m_gnt = -1;
      end
   endfunction

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic compare();
      check("gnt", 32'(gnt), m_gnt < 0 ? 0 : (1 << m_gnt));
      check("busy", 32'(busy), m_busy);
      check("rvalid", 32'(rvalid), m_rvalid);
      check("rdata", 32'(rdata), m_rdata);
      check("rid", 32'(rid), m_rid);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare();
   endtask

   task automatic set(int i, bit r, bit w, int a, int d);
      req[i] = r;
      wr[i] = w;
      addr[i*AW +: AW] = AW'(a);
      wdata[i*DW +: DW] = DW'(d);
   endtask

   task automatic do_reset();
      #1 rst = 1'b0;
      #1 model_reset();
      compare();
      tick();
      #2 rst = 1'b1;
   endtask

   task automatic single(int id, bit w, int a, int d, int exp);
      set(id, 1'b1, w, a, d);
      tick();
      check("single_gnt", 32'(gnt), 1 << id);
      tick();
      check("single_rvalid", 32'(rvalid), 1);
      check("single_rdata", 32'(rdata), exp);
      check("single_rid", 32'(rid), id);
      set(id, 1'b0, 1'b0, 0, 0);
   endtask

   initial begin
      bit served;
      model_reset();
      tick();
      tick();
      check("rst_gnt", 32'(gnt), 0);
      check("rst_rvalid", 32'(rvalid), 0);
      check("rst_rdata", 32'(rdata), 0);
      check("rst_busy", 32'(busy), 0);
      #2 rst = 1'b1;
      single(0, 1'b1, 2, 8'hA5, 8'h00);
      single(1, 1'b0, 2, 0, 8'hA5);

      do_reset();
      req = '1; wr = '0;
      for (int c = 0; c < 16; c++) begin
         tick();
         if (c % 2 == 0) check("rr_gnt", 32'(gnt), 1 << ((c/2) % 4));
         else check("rr_rid", 32'(rid), (c/2) % 4);
      end
      req = 4'b0101;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (c % 2 == 0) check("skip_gnt", 32'(gnt), (c/2) % 2 == 0 ? 4'b0001 : 4'b0100);
      end
      req = '0;
      tick();

      single(1, 1'b1, 1, 8'h3C, 8'h00);
      single(3, 1'b1, 1, 8'hC3, 8'h3C);
      single(0, 1'b0, 1, 0, 8'hC3);

      set(0, 1'b1, 1'b0, 0, 0);
      tick();
      check("wd_gnt", 32'(gnt), 4'b0001);
      set(2, 1'b1, 1'b0, 0, 0);
      tick();
      set(2, 1'b0, 1'b0, 0, 0);
      set(0, 1'b0, 1'b0, 0, 0);
      for (int c = 0; c < 4; c++) begin
         tick();
         check("wd_none", 32'(gnt), 0);
      end

      single(1, 1'b1, 3, 8'h55, 8'h00);
      set(3, 1'b1, 1'b1, 3, 8'hFF);
      tick();
      check("ar_gnt", 32'(gnt), 4'b1000);
      #2 rst = 1'b0;
      #1 model_reset();
      check("ar_gnt_drop", 32'(gnt), 0);
      compare();
      set(3, 1'b0, 1'b0, 0, 0);
      tick();
      check("ar_no_rvalid", 32'(rvalid), 0);
      #2 rst = 1'b1;
      set(1, 1'b1, 1'b0, 3, 0);
      set(2, 1'b1, 1'b0, 3, 0);
      tick();
      check("ar_first_gnt", 32'(gnt), 4'b0010);
      tick();
      check("ar_rdata", 32'(rdata), 0);
      check("ar_rid", 32'(rid), 1);
      req = '0;
      tick();

      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (m_busy != 0 && m_gnt == i) continue;
            served = (m_rvalid != 0 && m_rid == i);
            if (req[i] && !served) begin
               if ($urandom_range(0, 9) == 0) req[i] = 1'b0;
            end else if ($urandom_range(0, 1) == 1)
               set(i, 1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH-1)), int'($urandom_range(0, 255)));
            else req[i] = 1'b0;
         end
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
